// File: rtl/paddle_ctrl.sv
// Pong paddle position generator: buttons (or optional AI) to bounding box.
// Optional ball-tracking AI is built when PADDLE_AI_EN is defined.
module paddle_ctrl #(
  parameter int PX         = 20,
  parameter int PW         = 5,
  parameter int PH         = 40,
  parameter int IY         = 240,
  parameter int D_HEIGHT   = 480,
  parameter int MAX_SPD    = 4,
  parameter int ACC_FRAMES = 8,
  parameter int AI_SPD     = 2,
  parameter int AI_DB      = 4
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic        i_ani_stb,
  input  logic [1:0]  i_mode,
  input  logic        i_up,
  input  logic        i_dn,
  input  logic        i_ai_en,
  input  logic [11:0] i_ball_y,
  output logic [11:0] o_x1,
  output logic [11:0] o_x2,
  output logic [11:0] o_y1,
  output logic [11:0] o_y2,
  output logic        o_moving
);

  typedef enum logic [1:0] {IDLE, UP, DN} state_t;

  localparam logic [12:0] Y_MIN    = 13'(PH);
  localparam logic [12:0] Y_MAX    = 13'(D_HEIGHT - 1 - PH);
  localparam logic [11:0] Y_HOME   = 12'(IY);
  localparam logic [3:0]  SPD_MAX  = 4'(MAX_SPD);
  localparam logic [7:0]  ACC_LAST = 8'(ACC_FRAMES - 1);

  state_t      state_q, state_d;
  logic [11:0] y_q, y_d;
  logic [3:0]  spd_q, spd_d;
  logic [7:0]  hold_q, hold_d;
  logic        mov_q, mov_d;

  logic        ai_sel;
  state_t      ai_dir;
  state_t      btn_dir;

`ifdef PADDLE_AI_EN
  logic signed [12:0] ai_diff;
  assign ai_sel  = i_ai_en;
  assign ai_diff = $signed({1'b0, i_ball_y}) - $signed({1'b0, y_q});
  // AI chases the ball centre outside a small deadband
  always_comb begin
    ai_dir = IDLE;
    if (ai_diff > $signed(13'(AI_DB)))
      ai_dir = DN;
    else if (ai_diff < -$signed(13'(AI_DB)))
      ai_dir = UP;
  end
`else
  logic unused_ai;
  assign unused_ai = ^{i_ai_en, i_ball_y};
  assign ai_sel    = 1'b0;
  assign ai_dir    = IDLE;
`endif

  // Button level decode; both or neither pressed means stay put
  always_comb begin
    btn_dir = IDLE;
    unique case (1'b1)
      (i_up && !i_dn): btn_dir = UP;
      (i_dn && !i_up): btn_dir = DN;
      default:         btn_dir = IDLE;
    endcase
  end

  // Next-state: direction, speed ramp, clamped move, mode-drop home
  always_comb begin
    logic [12:0] y13;
    logic [12:0] step;
    logic [7:0]  hold_n;
    state_t      dir;
    state_d = state_q;
    y_d     = y_q;
    spd_d   = spd_q;
    hold_d  = hold_q;
    mov_d   = mov_q;
    y13     = {1'b0, y_q};
    step    = 13'd1;
    hold_n  = hold_q + 8'd1;
    dir     = IDLE;
    if (i_ani_stb) begin
      if (ai_sel) begin
        dir     = ai_dir;
        step    = 13'(AI_SPD);
        spd_d   = 4'd1;
        hold_d  = 8'd0;
        state_d = IDLE;
      end else begin
        dir     = btn_dir;
        state_d = btn_dir;
        if (btn_dir == IDLE || btn_dir != state_q) begin
          spd_d  = 4'd1;
          hold_d = 8'd0;
          step   = 13'd1;
        end else begin
          step = {9'd0, spd_q};
          if (hold_n >= ACC_LAST) begin
            hold_d = 8'd0;
            spd_d  = (spd_q < SPD_MAX) ? spd_q + 4'd1 : SPD_MAX;
          end else begin
            hold_d = hold_n;
          end
        end
      end
      case (dir)
        UP: y_d = (y13 < Y_MIN + step) ? Y_MIN[11:0]
                                       : 12'(y13 - step);
        DN: y_d = (y13 + step > Y_MAX) ? Y_MAX[11:0]
                                       : 12'(y13 + step);
        default: y_d = y_q;
      endcase
      mov_d = (y_d != y_q);
    end
    if (i_mode == 2'd0) begin
      state_d = IDLE;
      y_d     = Y_HOME;
      spd_d   = 4'd1;
      hold_d  = 8'd0;
      mov_d   = 1'b0;
    end
  end

  // State registers with synchronous active-low reset
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      state_q <= IDLE;
      y_q     <= Y_HOME;
      spd_q   <= 4'd1;
      hold_q  <= 8'd0;
      mov_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      y_q     <= y_d;
      spd_q   <= spd_d;
      hold_q  <= hold_d;
      mov_q   <= mov_d;
    end
  end

  assign o_x1     = 12'(PX - PW);
  assign o_x2     = 12'(PX + PW);
  assign o_y1     = y_q - 12'(PH);
  assign o_y2     = y_q + 12'(PH);
  assign o_moving = mov_q;

endmodule

// File: tb/tb_paddle_ctrl.sv
// Directed self-checking bench for paddle_ctrl.
// Expected positions are hand-computed from the paddle rules.
module tb_paddle_ctrl;

  logic        clk;
  logic        rst_n;
  logic        stb;
  logic [1:0]  mode;
  logic        up;
  logic        dn;
  logic        ai_en;
  logic [11:0] ball_y;
  logic [11:0] x1, x2, y1, y2;
  logic        moving;

  int pass_cnt;
  int total_cnt;

  paddle_ctrl dut (
    .i_clk     (clk),
    .i_rst_n   (rst_n),
    .i_ani_stb (stb),
    .i_mode    (mode),
    .i_up      (up),
    .i_dn      (dn),
    .i_ai_en   (ai_en),
    .i_ball_y  (ball_y),
    .o_x1      (x1),
    .o_x2      (x2),
    .o_y1      (y1),
    .o_y2      (y2),
    .o_moving  (moving)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic strobe();
    @(negedge clk);
    stb = 1'b1;
    @(negedge clk);
    stb = 1'b0;
  endtask

  task automatic chk12(input string nm,
                       input logic [11:0] act,
                       input logic [11:0] exp);
    total_cnt++;
    if (act !== exp)
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    else
      pass_cnt++;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    total_cnt++;
    if (x1 !== 12'd15)
      $display("FAIL reset_x1: got %0d expected 15", x1);
    else pass_cnt++;
    total_cnt++;
    if (x2 !== 12'd25)
      $display("FAIL reset_x2: got %0d expected 25", x2);
    else pass_cnt++;
    total_cnt++;
    if (y1 !== 12'd200)
      $display("FAIL reset_y1: got %0d expected 200", y1);
    else pass_cnt++;
    total_cnt++;
    if (y2 !== 12'd280)
      $display("FAIL reset_y2: got %0d expected 280", y2);
    else pass_cnt++;
    total_cnt++;
    if (moving !== 1'b0)
      $display("FAIL reset_moving: got %0b expected 0", moving);
    else pass_cnt++;
  endtask

  task automatic test_ramp_up();
    int ey;
    mode = 2'd1;
    up   = 1'b1;
    for (int i = 1; i <= 9; i++) begin
      strobe();
      ey = (i <= 8) ? 240 - i : 230;
      total_cnt++;
      if (y1 !== 12'(ey - 40))
        $display("FAIL ramp_y1[%0d]: got %0d expected %0d",
                 i, y1, ey - 40);
      else pass_cnt++;
    end
    total_cnt++;
    if (moving !== 1'b1)
      $display("FAIL ramp_moving: got %0b expected 1", moving);
    else pass_cnt++;
  endtask

  task automatic test_between_strobes();
    up = 1'b0;
    dn = 1'b1;
    repeat (4) @(negedge clk);
    total_cnt++;
    if (y1 !== 12'd190)
      $display("FAIL hold_y1: got %0d expected 190", y1);
    else pass_cnt++;
    total_cnt++;
    if (moving !== 1'b1)
      $display("FAIL hold_moving: got %0b expected 1", moving);
    else pass_cnt++;
  endtask

  task automatic test_clamp_down();
    up = 1'b0;
    dn = 1'b1;
    repeat (200) strobe();
    chk12("clamp_y2", y2, 12'd479);
    chk12("clamp_y1", y1, 12'd399);
    total_cnt++;
    if (moving !== 1'b0)
      $display("FAIL clamp_moving: got %0b expected 0", moving);
    else pass_cnt++;
  endtask

  task automatic test_both_buttons();
    up = 1'b1;
    dn = 1'b0;
    repeat (15) strobe();
    chk12("ramp3_y1", y1, 12'd377);
    dn = 1'b1;
    strobe();
    chk12("both_y1", y1, 12'd377);
    total_cnt++;
    if (moving !== 1'b0)
      $display("FAIL both_moving: got %0b expected 0", moving);
    else pass_cnt++;
    up = 1'b0;
    strobe();
    chk12("after_both_y1", y1, 12'd378);
    total_cnt++;
    if (moving !== 1'b1)
      $display("FAIL after_both_moving: got %0b expected 1", moving);
    else pass_cnt++;
  endtask

  task automatic test_mode_drop();
    up = 1'b0;
    dn = 1'b1;
    repeat (5) strobe();
    chk12("pre_drop_y1", y1, 12'd383);
    @(negedge clk);
    mode = 2'd0;
    @(negedge clk);
    mode = 2'd1;
    chk12("drop_y1", y1, 12'd200);
    total_cnt++;
    if (moving !== 1'b0)
      $display("FAIL drop_moving: got %0b expected 0", moving);
    else pass_cnt++;
    strobe();
    chk12("post_drop_y1", y1, 12'd201);
    @(negedge clk);
    mode = 2'd0;
    stb  = 1'b1;
    @(negedge clk);
    stb  = 1'b0;
    mode = 2'd1;
    chk12("drop_vs_stb_y1", y1, 12'd200);
  endtask

  task automatic test_reset_mid_ramp();
    up = 1'b0;
    dn = 1'b1;
    repeat (10) strobe();
    chk12("rramp_y1", y1, 12'd212);
    @(negedge clk);
    rst_n = 1'b0;
    stb   = 1'b1;
    @(negedge clk);
    rst_n = 1'b1;
    stb   = 1'b0;
    chk12("rst_mid_y1", y1, 12'd200);
    total_cnt++;
    if (moving !== 1'b0)
      $display("FAIL rst_mid_moving: got %0b expected 0", moving);
    else pass_cnt++;
    strobe();
    chk12("rst_post_y1", y1, 12'd201);
  endtask

`ifdef PADDLE_AI_EN
  task automatic test_ai();
    rst_n = 1'b0;
    @(negedge clk);
    rst_n  = 1'b1;
    mode   = 2'd1;
    ai_en  = 1'b1;
    ball_y = 12'd300;
    up     = 1'b1;
    dn     = 1'b0;
    strobe();
    chk12("ai_first_y1", y1, 12'd202);
    repeat (27) strobe();
    chk12("ai_reach_y1", y1, 12'd256);
    strobe();
    chk12("ai_hold_y1", y1, 12'd256);
    total_cnt++;
    if (moving !== 1'b0)
      $display("FAIL ai_moving: got %0b expected 0", moving);
    else pass_cnt++;
    ai_en = 1'b0;
  endtask
`endif

  initial begin
    pass_cnt  = 0;
    total_cnt = 0;
    rst_n  = 1'b0;
    stb    = 1'b0;
    mode   = 2'd0;
    up     = 1'b0;
    dn     = 1'b0;
    ai_en  = 1'b0;
    ball_y = 12'd0;
    test_reset();
    test_ramp_up();
    test_between_strobes();
    test_clamp_down();
    test_both_buttons();
    test_mode_drop();
    test_reset_mid_ramp();
`ifdef PADDLE_AI_EN
    test_ai();
`endif
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
